// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver: carry-save pair in, resolved binary sum out.
interface csa_resolver_if #(parameter int NN = 16);
   logic [NN:0]   cs_sum;
   logic [NN:0]   cs_carry;
   logic          in_valid;
   logic          in_ready;
   logic [NN+1:0] result;
   logic          out_valid;
   logic          out_ready;

   modport master (output cs_sum, cs_carry, in_valid, out_ready,
                   input  in_ready, result, out_valid);
   modport slave  (input  cs_sum, cs_carry, in_valid, out_ready,
                   output in_ready, result, out_valid);
endinterface

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate adder: resolves a carry-save pair CW bits per cycle, LSB chunk first.
module csa_resolver #(
   parameter int NN = 16,
   parameter int CW = 4
) (
   input logic           clk,
   input logic           rst_n,
   csa_resolver_if.slave bus
);
   localparam int W   = NN + 1;
   localparam int NCH = (W + CW - 1) / CW;
   localparam int PW  = NCH * CW;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   a, b, acc, acc_nxt;
   logic [PW-1:0]   sum_ext, carry_ext;
   logic            cy;
   logic [IW-1:0]   idx;
   logic [CW:0]     chunk;
   logic            last;
   logic [NN+1:0]   result_q, result_nxt;

   always_comb begin
      sum_ext            = '0;
      carry_ext          = '0;
      sum_ext[W-1:0]     = bus.cs_sum;
      carry_ext[W-1:0]   = bus.cs_carry;
      chunk = {1'b0, a[int'(idx)*CW +: CW]} + {1'b0, b[int'(idx)*CW +: CW]} + {{CW{1'b0}}, cy};
      // The final chunk lands in acc on the same edge result is captured, so build result from the merged value.
      acc_nxt                      = acc;
      acc_nxt[int'(idx)*CW +: CW]  = chunk[CW-1:0];
      result_nxt = (NN+2)'({chunk[CW], acc_nxt});
      last       = (idx == IW'(NCH - 1));
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a        <= '0;
         b        <= '0;
         acc      <= '0;
         cy       <= 1'b0;
         idx      <= '0;
         result_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a   <= sum_ext;
                  b   <= carry_ext;
                  acc <= '0;
                  cy  <= 1'b0;
                  idx <= '0;
               end
            end
            BUSY: begin
               acc <= acc_nxt;
               cy  <= chunk[CW];
               idx <= last ? '0 : idx + 1'b1;
               if (last) result_q <= result_nxt;
            end
            default: ;
         endcase
      end
   end

   assign bus.result = result_q;
endmodule
